// File: rtl/uart_mem_dump_pkg.sv
// Shared types and constants for the UART memory dump path and its loader counterpart.
package uart_mem_dump_pkg;

  localparam logic [15:0] TermWordDefault = 16'hffff;

  // Dump FSM states; the byte pacer reuses StIdle/StSend/StGap/StWait for its own handshake.
  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StLatch,
    StSend,
    StGap,
    StWait,
    StTermHi,
    StTermLo
  } dump_state_e;

endpackage

// File: rtl/uart_byte_pacer.sv
// Paces single bytes into the UART: SEND waits for ready and strobes tx_en, GAP skips the
// UART's ready-deassert latency, WAIT holds until the UART can take the next byte.
module uart_byte_pacer
  import uart_mem_dump_pkg::*;
(
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic       o_done
);

  dump_state_e r_state;
  dump_state_e w_state_next;
  logic [7:0]  r_tx_data;

  always_comb begin
    w_state_next = r_state;
    o_tx_en      = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      StSend: begin
        if (i_tx_ready) begin
          o_tx_en      = 1'b1;
          w_state_next = StGap;
        end
      end
      StGap:  w_state_next = StWait;
      StWait: begin
        if (i_tx_ready) begin
          o_done       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
    // A new byte may be queued in the same cycle the previous one completes.
    if (i_load) begin
      w_state_next = StSend;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (i_load) begin
        r_tx_data <= i_byte;
      end
    end
  end

  assign o_tx_data = r_tx_data;

endmodule

// File: rtl/uart_mem_dump.sv
// Streams a BRAM word range out of the UART high byte first, then appends the end marker,
// mirroring the program loader's wire format.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [15:0] TERM_WORD  = TermWordDefault
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_rd_data,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_en,
  output logic                  busy,
  output logic                  done
);

  dump_state_e           r_state;
  dump_state_e           w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [ADDR_WIDTH:0]   r_remain;
  logic [ADDR_WIDTH:0]   w_remain_next;
  logic [ADDR_WIDTH:0]   w_remain_dec;
  logic [7:0]            r_lo;
  logic [7:0]            w_lo_next;
  logic                  r_phase_lo;
  logic                  w_phase_lo_next;
  logic                  w_load;
  logic [7:0]            w_load_byte;
  logic                  w_pace_done;

  assign w_remain_dec = r_remain - 1'b1;

  always_comb begin
    w_state_next    = r_state;
    w_addr_next     = r_addr;
    w_remain_next   = r_remain;
    w_lo_next       = r_lo;
    w_phase_lo_next = r_phase_lo;
    w_load          = 1'b0;
    w_load_byte     = 8'h00;
    done            = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_addr_next     = base_addr;
          w_remain_next   = word_count;
          w_phase_lo_next = 1'b0;
          if (word_count == '0) begin
            w_load       = 1'b1;
            w_load_byte  = TERM_WORD[15:8];
            w_state_next = StTermHi;
          end else begin
            w_state_next = StRd;
          end
        end
      end
      StRd: w_state_next = StLatch;
      StLatch: begin
        // High byte goes straight to the pacer; only the low byte needs holding.
        w_lo_next       = mem_rd_data[7:0];
        w_phase_lo_next = 1'b0;
        w_load          = 1'b1;
        w_load_byte     = mem_rd_data[15:8];
        w_state_next    = StSend;
      end
      StSend: begin
        if (w_pace_done) begin
          if (!r_phase_lo) begin
            w_phase_lo_next = 1'b1;
            w_load          = 1'b1;
            w_load_byte     = r_lo;
          end else begin
            w_addr_next   = r_addr + 1'b1;
            w_remain_next = w_remain_dec;
            if (w_remain_dec == '0) begin
              w_load       = 1'b1;
              w_load_byte  = TERM_WORD[15:8];
              w_state_next = StTermHi;
            end else begin
              w_state_next = StRd;
            end
          end
        end
      end
      StTermHi: begin
        if (w_pace_done) begin
          w_load       = 1'b1;
          w_load_byte  = TERM_WORD[7:0];
          w_state_next = StTermLo;
        end
      end
      StTermLo: begin
        if (w_pace_done) begin
          done         = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_remain   <= '0;
      r_lo       <= 8'h00;
      r_phase_lo <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_remain   <= w_remain_next;
      r_lo       <= w_lo_next;
      r_phase_lo <= w_phase_lo_next;
    end
  end

  uart_byte_pacer u_pacer (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_byte     (w_load_byte),
    .i_tx_ready (tx_ready),
    .o_tx_data  (tx_data),
    .o_tx_en    (tx_en),
    .o_done     (w_pace_done)
  );

  assign mem_addr = r_addr;
  assign busy     = (r_state != StIdle);

endmodule
